sram_burst_ctrl: RTL and testbench

Burst access controller that drives the port of an `sram` instance, i.e. the initiator side of the `en_i/we_i/addr_i/data_i/data_o` interface.
- Accepts one line command at a time and runs one of two bursts of BURST_LEN sequential words:
  - fill: streams write data from a valid/ready channel into the SRAM;
  - drain: streams SRAM read data out on a valid/ready channel, with full throughput and backpressure.
- Sits between a cache's refill/write-back logic and its tag/data `sram` arrays.

---
 rtl/sram_burst_ctrl.sv | 127 ++++++++++++
 tb/tb_sram_burst_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// rtl/sram_burst_ctrl.sv - Line-burst fill/drain controller driving a single-port sram
module sram_burst_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int N_ENTRIES  = 1024,
    parameter int BURST_LEN  = 8,
    localparam int AW = $clog2(N_ENTRIES),
    localparam int LB = $clog2(BURST_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [AW-1:0]         cmd_addr_i,

    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,

    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,

    output logic                  done_o,

    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_data_o,
    input  logic [DATA_WIDTH-1:0] sram_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] LINE_MASK = AW'(BURST_LEN - 1);
    localparam logic [LB:0]   CNT_LAST  = (LB+1)'(BURST_LEN - 1);
    localparam logic [LB:0]   CNT_ONE   = (LB+1)'(1);

    state_t          state;
    logic [AW-1:0]   base;
    logic [LB:0]     beat_cnt;
    logic [LB:0]     issue_cnt;
    logic            rd_valid_q;
    logic            done_q;

    logic            wr_hs;
    logic            rd_hs;
    logic            issue;
    logic [LB-1:0]   line_off;

    assign cmd_ready_o = (state == IDLE);
    assign wr_ready_o  = (state == FILL);
    assign wr_hs       = wr_valid_i && (state == FILL);
    assign rd_hs       = rd_valid_q && rd_ready_i;

    // A read is issued only when the output slot is free or being emptied this cycle;
    // while stalled the sram keeps presenting the last word, so no skid buffer is needed.
    assign issue = (state == DRAIN) && !issue_cnt[LB] && (!rd_valid_q || rd_ready_i);

    // Offset stays within the aligned line: no carry into the base bits.
    assign line_off    = (state == DRAIN) ? issue_cnt[LB-1:0] : beat_cnt[LB-1:0];
    assign sram_addr_o = base | AW'(line_off);

    assign sram_en_o   = wr_hs || issue;
    assign sram_we_o   = wr_hs;
    assign sram_data_o = wr_data_i;

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = sram_data_i;
    assign done_o      = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            base       <= '0;
            beat_cnt   <= '0;
            issue_cnt  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        base      <= cmd_addr_i & ~LINE_MASK;
                        beat_cnt  <= '0;
                        issue_cnt <= '0;
                        state     <= cmd_we_i ? FILL : DRAIN;
                    end
                end
                FILL: begin
                    if (wr_hs) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                        if (beat_cnt == CNT_LAST) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + CNT_ONE;
                    end
                    if (issue) begin
                        rd_valid_q <= 1'b1;
                    end else if (rd_hs) begin
                        rd_valid_q <= 1'b0;
                    end
                    if (rd_hs) begin
                        beat_cnt <= beat_cnt + CNT_ONE;
                        if (beat_cnt == CNT_LAST) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb/tb_sram_burst_ctrl.sv - Directed self-checking bench for sram_burst_ctrl
module tb_sram_burst_ctrl;

    localparam int DW = 32;
    localparam int NE = 1024;
    localparam int BL = 8;
    localparam int AW = 10;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic          wr_valid_i = 1'b0;
    logic          wr_ready_o;
    logic [DW-1:0] wr_data_i = '0;
    logic          rd_valid_o;
    logic          rd_ready_i = 1'b0;
    logic [DW-1:0] rd_data_o;
    logic          done_o;
    logic          sram_en_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_data_o;
    logic [DW-1:0] sram_data_i;

    int n_tests = 0;
    int n_fail  = 0;
    int en_count = 0;

    logic [DW-1:0] mem [0:NE-1];

    sram_burst_ctrl #(
        .DATA_WIDTH(DW),
        .N_ENTRIES (NE),
        .BURST_LEN (BL)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_we_i   (cmd_we_i),
        .cmd_addr_i (cmd_addr_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_data_i  (wr_data_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .done_o     (done_o),
        .sram_en_o  (sram_en_o),
        .sram_we_o  (sram_we_o),
        .sram_addr_o(sram_addr_o),
        .sram_data_o(sram_data_o),
        .sram_data_i(sram_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural sram: registered read port that holds its output while en is low.
    initial begin
        for (int i = 0; i < NE; i++) mem[i] = 32'hDEAD_0000 + i;
        sram_data_i = '0;
        forever begin
            @(posedge clk_i);
            if (sram_en_o) begin
                en_count <= en_count + 1;
                if (sram_we_o) mem[sram_addr_o] <= sram_data_o;
                else           sram_data_i      <= mem[sram_addr_o];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    logic [15:0] rpat = 16'b0110_1101_0110_1001;
    logic [15:0] wpat = 16'b1111_1111_0100_1101;

    initial begin
        int k;
        int en0;
        bit seen_done;

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_wr_ready",  wr_ready_o, 0);
        chk("rst_rd_valid",  rd_valid_o, 0);
        chk("rst_done",      done_o, 0);
        chk("rst_sram_en",   sram_en_o, 0);
        chk("rst_sram_we",   sram_we_o, 0);
        rst_i = 1'b0;
        tick;

        // Fill at 0x013 with wr_valid held high
        cmd_valid_i = 1; cmd_we_i = 1; cmd_addr_i = 10'h013;
        wr_valid_i = 1; wr_data_i = 32'hA0;
        #1;
        chk("fill1_idle_en", sram_en_o, 0);
        tick;
        cmd_valid_i = 0;
        for (int i = 0; i < BL; i++) begin
            wr_data_i = 32'hA0 + i;
            #1;
            chk("fill1_wr_ready", wr_ready_o, 1);
            chk("fill1_en",   sram_en_o, 1);
            chk("fill1_we",   sram_we_o, 1);
            chk("fill1_addr", sram_addr_o, 10'h010 + i);
            chk("fill1_done_early", done_o, 0);
            tick;
        end
        wr_valid_i = 0;
        #1;
        chk("fill1_done", done_o, 1);
        chk("fill1_cmd_ready", cmd_ready_o, 1);
        chk("fill1_post_en", sram_en_o, 0);
        tick;
        chk("fill1_done_pulse", done_o, 0);
        for (int i = 0; i < BL; i++) chk("fill1_mem", mem[10'h010 + i], 32'hA0 + i);
        chk("fill1_mem_below", mem[10'h00F], 32'hDEAD_000F);
        chk("fill1_mem_above", mem[10'h018], 32'hDEAD_0018);

        // Drain of that line with rd_ready held high
        cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 10'h013; rd_ready_i = 1;
        en0 = en_count;
        tick;
        cmd_valid_i = 0;
        #1;
        chk("drain1_first_en", sram_en_o, 1);
        chk("drain1_first_we", sram_we_o, 0);
        chk("drain1_first_addr", sram_addr_o, 10'h010);
        chk("drain1_rd_valid_t1", rd_valid_o, 0);
        chk("drain1_wr_ready", wr_ready_o, 0);
        tick;
        for (int i = 0; i < BL; i++) begin
            #1;
            chk("drain1_rd_valid", rd_valid_o, 1);
            chk("drain1_data", rd_data_o, 32'hA0 + i);
            chk("drain1_done_early", done_o, 0);
            tick;
        end
        #1;
        chk("drain1_done", done_o, 1);
        chk("drain1_rd_valid_end", rd_valid_o, 0);
        chk("drain1_en_pulses", en_count - en0, 8);
        rd_ready_i = 0;
        tick;

        // Drain with rd_ready pattern 1,0,0,1,... then random stalls
        cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 10'h017;
        tick;
        cmd_valid_i = 0;
        k = 0;
        seen_done = 0;
        for (int c = 0; c < 80 && !seen_done; c++) begin
            rd_ready_i = (c < 16) ? rpat[c] : ($urandom_range(0, 1) == 1);
            #1;
            if (done_o) begin
                seen_done = 1;
            end else begin
                if (rd_valid_o) begin
                    chk("drain2_data", rd_data_o, 32'hA0 + k);
                    if (!rd_ready_i) chk("drain2_stall_en", sram_en_o, 0);
                    else k++;
                end
                tick;
            end
        end
        chk("drain2_count", k, 8);
        chk("drain2_done", seen_done, 1);
        rd_ready_i = 0;
        tick;

        // Fill with wr_valid gaps; next command held pending throughout
        cmd_valid_i = 1; cmd_we_i = 1; cmd_addr_i = 10'h020;
        #1;
        chk("fill2_accept_ready", cmd_ready_o, 1);
        tick;
        cmd_addr_i = 10'h3F8;
        k = 0;
        for (int c = 0; c < 40 && k < BL; c++) begin
            wr_valid_i = wpat[c];
            wr_data_i  = wpat[c] ? 32'hB0 + k : 32'hEE;
            #1;
            chk("fill2_busy", cmd_ready_o, 0);
            chk("fill2_en", sram_en_o, wpat[c]);
            if (wpat[c]) begin
                chk("fill2_addr", sram_addr_o, 10'h020 + k);
                k++;
            end
            tick;
        end
        wr_valid_i = 0;
        #1;
        chk("fill2_count", k, 8);
        chk("fill2_done", done_o, 1);
        chk("fill2_cmd_ready_in_done", cmd_ready_o, 1);
        tick;
        cmd_valid_i = 0;
        #1;
        chk("fill3_started", wr_ready_o, 1);
        chk("fill3_busy", cmd_ready_o, 0);

        // Pending command is a fill of the last line: 0x3F8..0x3FF, no wrap
        for (int i = 0; i < BL; i++) begin
            wr_valid_i = 1;
            wr_data_i = 32'hC0 + i;
            #1;
            chk("fill3_addr", sram_addr_o, 10'h3F8 + i);
            tick;
        end
        wr_valid_i = 0;
        #1;
        chk("fill3_done", done_o, 1);
        tick;
        chk("fill3_single_accept", cmd_ready_o, 1);
        chk("fill3_no_restart", wr_ready_o, 0);
        for (int i = 0; i < BL; i++) chk("fill2_mem", mem[10'h020 + i], 32'hB0 + i);
        for (int i = 0; i < BL; i++) chk("fill3_mem", mem[10'h3F8 + i], 32'hC0 + i);
        chk("fill3_no_wrap", mem[10'h000], 32'hDEAD_0000);
        chk("fill3_mem_below", mem[10'h3F7], 32'hDEAD_03F7);
        chk("fill2_mem_above", mem[10'h028], 32'hDEAD_0028);

        // Reset in the middle of a drain after 3 words
        cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 10'h010; rd_ready_i = 1;
        tick;
        cmd_valid_i = 0;
        tick;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("drain3_pre_data", rd_data_o, 32'hA0 + i);
            tick;
        end
        rst_i = 1;
        #1;
        chk("rst_mid_rd_valid", rd_valid_o, 0);
        chk("rst_mid_sram_en", sram_en_o, 0);
        chk("rst_mid_cmd_ready", cmd_ready_o, 1);
        chk("rst_mid_done", done_o, 0);
        chk("rst_mid_wr_ready", wr_ready_o, 0);
        tick;
        rst_i = 0;
        tick;

        // Fresh drain returns the full line from word 0
        cmd_valid_i = 1; cmd_we_i = 0; cmd_addr_i = 10'h015;
        en0 = en_count;
        tick;
        cmd_valid_i = 0;
        #1;
        chk("drain4_first_addr", sram_addr_o, 10'h010);
        tick;
        for (int i = 0; i < BL; i++) begin
            #1;
            chk("drain4_rd_valid", rd_valid_o, 1);
            chk("drain4_data", rd_data_o, 32'hA0 + i);
            tick;
        end
        #1;
        chk("drain4_done", done_o, 1);
        chk("drain4_en_pulses", en_count - en0, 8);
        rd_ready_i = 0;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
